// File: rtl/rr_grant_sched_8_if.sv
// Request/grant bundle between the requesters (master) and the round-robin scheduler (slave).
`timescale 1ns/1ps
interface rr_grant_sched_8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (output req, done, input gnt, gnt_idx, gnt_valid, timeout);
    modport slave  (input req, done, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_grant_sched_8.sv
// Eight-way round-robin grant scheduler with a hold limit per grant.
// Outputs come straight from flops; a released holder drops to the back of the search order.
`timescale 1ns/1ps
module rr_grant_sched_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    rr_grant_sched_8_if.slave  bus
);
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] gnt_q, gnt_d;
    logic       timeout_q, timeout_d;

    logic [2:0] pick;
    logic       hold_hit;
    logic       holder_req;

    // Walk the search order backwards so the last hit is the one nearest ptr.
    always_comb begin
        pick = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            if (bus.req[ptr_q + 3'(i)]) pick = ptr_q + 3'(i);
        end
    end

    assign hold_hit   = (hold_q == HOLD_LAST);
    assign holder_req = bus.req[idx_q];

    // NOTE: every variable is defaulted before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_GRANT;
                    idx_d   = pick;
                    gnt_d   = 8'b1 << pick;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (bus.done || !holder_req || hold_hit) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    ptr_d     = idx_q + 3'd1;
                    hold_d    = '0;
                    // Only a revoke forced purely by the limit is reported.
                    timeout_d = hold_hit && !bus.done && holder_req;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: reset is asynchronous and clears every flop, aborting any grant without a release pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = (state_q == ST_GRANT);
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_grant_sched_8.sv
// Bench for rr_grant_sched_8: directed scenarios plus randomized traffic against a
// cycle-level reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_rr_grant_sched_8;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_grant_sched_8_if bus();

    rr_grant_sched_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    logic [12:0] dut_vec;
    assign dut_vec = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};

    // Reference model: who holds the grant, for how many completed cycles, and where the search starts.
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_held;
    bit m_timeout;

    task automatic model_reset();
        m_busy    = 1'b0;
        m_idx     = 0;
        m_ptr     = 0;
        m_held    = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_step();
        bit still_wanted;
        bit at_limit;
        if (rst) begin
            model_reset();
            return;
        end
        m_timeout = 1'b0;
        if (m_busy) begin
            still_wanted = bus.req[m_idx];
            at_limit     = (m_held + 1 == MAX_HOLD);
            if (bus.done || !still_wanted || at_limit) begin
                m_busy    = 1'b0;
                m_ptr     = (m_idx + 1) % 8;
                m_timeout = at_limit && !bus.done && still_wanted;
            end else begin
                m_held = m_held + 1;
            end
        end else if (bus.req != 8'h00) begin
            for (int k = 7; k >= 0; k--) begin
                if (bus.req[(m_ptr + k) % 8]) m_idx = (m_ptr + k) % 8;
            end
            m_busy = 1'b1;
            m_held = 0;
        end
    endtask

    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        g = m_busy ? 8'(1 << m_idx) : 8'h00;
        return {g, 3'(m_idx), m_busy, m_timeout};
    endfunction

    // One clock: edge, model update, then settle before anyone samples.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        #2;
        rst      = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    // Grant encoding invariant, checked every cycle.
    always @(negedge clk) begin
        if (checking) begin
            n_cmp++;
            if (bus.gnt !== (bus.gnt_valid ? 8'(1 << bus.gnt_idx) : 8'h00) || $countones(bus.gnt) > 1) begin
                n_bad++;
                $display("FAIL onehot: gnt=%b valid=%b idx=%0d", bus.gnt, bus.gnt_valid, bus.gnt_idx);
            end
        end
    end

    task automatic test_reset();
        bus.req  = 8'h00;
        bus.done = 1'b0;
        rst      = 1'b1;
        model_reset();
        tick();
        tick();
        n_cmp++;
        if (dut_vec !== 13'h0000) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 0000", dut_vec);
        end
        #3;
        rst = 1'b0;
        checking = 1'b1;
        // Idle with done high and no requests must stay idle.
        bus.done = 1'b1;
        tick();
        n_cmp++;
        if (dut_vec !== 13'h0000) begin
            n_bad++;
            $display("FAIL idle_ignores_done: got %h want 0000", dut_vec);
        end
        bus.done = 1'b0;
    endtask

    task automatic test_alternate();
        apply_reset();
        bus.req = 8'b1000_0001;
        for (int g = 0; g < 4; g++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec() || bus.gnt_idx !== ((g % 2 == 1) ? 3'd7 : 3'd0) || bus.gnt_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL alt_grant%0d: got %h want idx %0d", g, dut_vec, (g % 2 == 1) ? 7 : 0);
            end
            bus.done = 1'b1;
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec() || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL alt_gap%0d: got %h want %h", g, dut_vec, exp_vec());
            end
            bus.done = 1'b0;
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        bus.req = 8'b0010_0000;
        tick();
        n_cmp++;
        if (bus.gnt_idx !== 3'd5 || bus.gnt_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_first: got idx %0d valid %b want 5/1", bus.gnt_idx, bus.gnt_valid);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 8'b0000_0011;
        tick();
        n_cmp++;
        if (bus.gnt !== 8'b0000_0001 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL wrap_idx0: got %h want gnt 01", dut_vec);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        n_cmp++;
        if (bus.gnt !== 8'b0000_0010 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL wrap_idx1: got %h want gnt 02", dut_vec);
        end
    endtask

    task automatic test_hold_limit();
        apply_reset();
        bus.req = 8'b0000_0100;
        for (int c = 0; c < MAX_HOLD; c++) begin
            tick();
            n_cmp++;
            if (bus.gnt !== 8'b0000_0100 || bus.gnt_valid !== 1'b1 || bus.timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got %h want gnt 04 valid", c, dut_vec);
            end
        end
        tick();
        n_cmp++;
        if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_timeout: got %h want gap with timeout", dut_vec);
        end
        tick();
        n_cmp++;
        if (bus.gnt_idx !== 3'd2 || bus.gnt_valid !== 1'b1 || bus.timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_regrant: got %h want idx 2 valid", dut_vec);
        end
        // done coinciding with the limit suppresses timeout
        for (int c = 1; c < MAX_HOLD; c++) tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        n_cmp++;
        if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL limit_with_done: got %h want %h", dut_vec, exp_vec());
        end
        // req drop coinciding with the limit suppresses timeout
        tick();
        for (int c = 1; c < MAX_HOLD; c++) tick();
        bus.req = 8'h00;
        tick();
        n_cmp++;
        if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL limit_with_drop: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_done_all();
        apply_reset();
        bus.req = 8'b0000_1000;
        tick();
        n_cmp++;
        if (bus.gnt_idx !== 3'd3 || bus.gnt_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL doneall_holder: got %h want idx 3", dut_vec);
        end
        bus.req  = 8'hFF;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        n_cmp++;
        if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL doneall_gap: got %h want 0 gap", dut_vec);
        end
        tick();
        n_cmp++;
        if (bus.gnt !== 8'b0001_0000 || bus.gnt_idx !== 3'd4 || bus.timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL doneall_next: got %h want idx 4", dut_vec);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        bus.req = 8'b0010_0000;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec !== 13'h0000) begin
            n_bad++;
            $display("FAIL abort_immediate: got %h want 0000", dut_vec);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.gnt !== 8'b0010_0000 || bus.gnt_idx !== 3'd5 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL abort_regrant: got %h want idx 5", dut_vec);
        end
        // Move ptr to 6, grant 5 again, then abort: search must restart at 0.
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        rst     = 1'b0;
        bus.req = 8'b0100_0001;
        tick();
        n_cmp++;
        if (bus.gnt_idx !== 3'd0 || bus.gnt_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_ptr: got idx %0d want 0", bus.gnt_idx);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 7))
                0:       bus.req = 8'h00;
                1, 2:    bus.req = 8'($urandom);
                3:       bus.req = 8'hFF;
                default: begin
                    r = bus.req;
                    if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
                    bus.req = r;
                end
            endcase
            bus.done = ($urandom_range(0, 4) == 0);
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got %h want %h", n, dut_vec, exp_vec());
            end
        end
        bus.req  = 8'h00;
        bus.done = 1'b0;
    endtask

    initial begin
        bus.req  = 8'h00;
        bus.done = 1'b0;
        test_reset();
        test_alternate();
        test_wrap();
        test_hold_limit();
        test_done_all();
        test_abort();
        test_random();
        tick();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
